ct_l2cache_dirty_array_nway: RTL and testbench

CT_L2CACHE_DIRTY_ARRAY_NWAY -- requirements
Module: ct_l2cache_dirty_array_nway

---
 rtl/ct_l2cache_dirty_array_nway.sv | 159 +++++++++++++++
 tb/tb_ct_l2cache_dirty_array_nway.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_l2cache_dirty_array_nway.sv
// ============================================================================
// Module   : ct_l2cache_dirty_array_nway
// Function : N-way L2 dirty/state array with read, masked write and read-and-clear.
//            L2C_DIRTY_INIT_EN builds the post-reset zeroing sweep.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ct_l2cache_dirty_array_nway #(
  parameter  int TAG_INDEX_WIDTH = 9,
  parameter  int WAY_NUM         = 16,
  parameter  int WAY_BITS        = 9,
  localparam int DW              = WAY_NUM * WAY_BITS
) (
  input  logic                       dirty_clk,
  input  logic                       cpurst_b,
  input  logic                       req_vld,
  output logic                       req_rdy,
  input  logic [1:0]                 req_op,
  input  logic [TAG_INDEX_WIDTH-1:0] req_idx,
  input  logic [DW-1:0]              req_din,
  input  logic [DW-1:0]              req_wen,
  output logic                       rd_vld,
  output logic [DW-1:0]              rd_dout,
  output logic                       init_done
);

  localparam int DEPTH = 1 << TAG_INDEX_WIDTH;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RCLR  = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLR   = 2'd1;
`ifdef L2C_DIRTY_INIT_EN
  localparam logic [1:0] ST_INIT  = 2'd2;
  localparam logic [1:0] ST_RESET = ST_INIT;
`else
  localparam logic [1:0] ST_RESET = ST_IDLE;
`endif

  logic [1:0]                 state_q, state_d;
  logic [DW-1:0]              mem_q [DEPTH];
  logic                       pipe_vld_q;
  logic [DW-1:0]              pipe_data_q;
  logic                       rd_vld_q;
  logic [DW-1:0]              rd_dout_q;
  logic [TAG_INDEX_WIDTH-1:0] clr_idx_q;
  logic [DW-1:0]              clr_wen_q;

  logic                       acc;
  logic                       acc_rd;
  logic                       mem_we;
  logic [TAG_INDEX_WIDTH-1:0] mem_addr;
  logic [DW-1:0]              mem_wdata;
  logic [DW-1:0]              mem_mask;

  // Reset gates every array access so cpurst_b never modifies contents.
  assign acc    = req_vld && req_rdy && cpurst_b;
  assign acc_rd = acc && (req_op != OP_WRITE);

`ifdef L2C_DIRTY_INIT_EN
  logic [TAG_INDEX_WIDTH-1:0] init_cnt_q;
  logic                       init_last;

  assign init_last = (init_cnt_q == '1);

  always_ff @(posedge dirty_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      init_cnt_q <= '0;
    end else if (state_q == ST_INIT && !init_last) begin
      init_cnt_q <= init_cnt_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge dirty_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef L2C_DIRTY_INIT_EN
      ST_INIT: if (init_last) state_d = ST_IDLE;
`endif
      ST_IDLE: if (acc && req_op == OP_RCLR) state_d = ST_CLR;
      ST_CLR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_rdy   = 1'b0;
    init_done = 1'b1;
    mem_we    = 1'b0;
    mem_addr  = req_idx;
    mem_wdata = req_din;
    mem_mask  = req_wen;
    case (state_q)
`ifdef L2C_DIRTY_INIT_EN
      ST_INIT: begin
        init_done = 1'b0;
        mem_we    = cpurst_b;
        mem_addr  = init_cnt_q;
        mem_wdata = '0;
        mem_mask  = '1;
      end
`endif
      ST_IDLE: begin
        req_rdy = 1'b1;
        mem_we  = acc && (req_op == OP_WRITE);
      end
      ST_CLR: begin
        mem_we    = cpurst_b;
        mem_addr  = clr_idx_q;
        mem_wdata = '0;
        mem_mask  = clr_wen_q;
      end
      default: ;
    endcase
  end

  // Storage and read capture carry no reset; contents survive cpurst_b.
  always_ff @(posedge dirty_clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= (mem_q[mem_addr] & ~mem_mask) | (mem_wdata & mem_mask);
    end
    if (acc_rd) begin
      pipe_data_q <= mem_q[req_idx];
      clr_idx_q   <= req_idx;
      clr_wen_q   <= req_wen;
    end
  end

  always_ff @(posedge dirty_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      pipe_vld_q <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_dout_q  <= '0;
    end else begin
      pipe_vld_q <= acc_rd;
      rd_vld_q   <= pipe_vld_q;
      if (pipe_vld_q) begin
        rd_dout_q <= pipe_data_q;
      end
    end
  end

  assign rd_vld  = rd_vld_q;
  assign rd_dout = rd_dout_q;

endmodule

`default_nettype wire

// File: tb/tb_ct_l2cache_dirty_array_nway.sv
// Bench for ct_l2cache_dirty_array_nway: directed and random traffic against a
// transaction-level array model (memory image + expected-read queue).
`default_nettype none

module tb_ct_l2cache_dirty_array_nway;

  localparam int TIW   = 9;
  localparam int DW    = 16 * 9;
  localparam int DEPTH = 1 << TIW;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RC = 2'b10;

`ifdef L2C_DIRTY_INIT_EN
  localparam logic RST_INIT_DONE = 1'b0;
`else
  localparam logic RST_INIT_DONE = 1'b1;
`endif

  logic           clk;
  logic           rst_n;
  logic           vld;
  logic           rdy;
  logic [1:0]     op;
  logic [TIW-1:0] idx;
  logic [DW-1:0]  din;
  logic [DW-1:0]  wen;
  logic           rd_vld;
  logic [DW-1:0]  rd_dout;
  logic           init_done;

  ct_l2cache_dirty_array_nway #(
    .TAG_INDEX_WIDTH(TIW),
    .WAY_NUM        (16),
    .WAY_BITS       (9)
  ) dut (
    .dirty_clk(clk),
    .cpurst_b (rst_n),
    .req_vld  (vld),
    .req_rdy  (rdy),
    .req_op   (op),
    .req_idx  (idx),
    .req_din  (din),
    .req_wen  (wen),
    .rd_vld   (rd_vld),
    .rd_dout  (rd_dout),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } exp_t;

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic [DW-1:0] mem_m [DEPTH];
  exp_t          q [$];
  logic [DW-1:0] last_d;
  bit            busy;
  logic [TIW-1:0] pend_idx;
  logic [DW-1:0] pend_wen;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_dw();
    logic [DW-1:0] v;
    for (int i = 0; i < DW; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // One clock: model the accept, advance, then compare outputs for the new cycle.
  task automatic tick();
    bit acc;
    acc = vld && !busy;
    @(posedge clk);
    cyc++;
    if (busy) begin
      mem_m[pend_idx] = mem_m[pend_idx] & ~pend_wen;
      busy = 1'b0;
    end
    if (acc) begin
      if (op == OP_WR) begin
        mem_m[idx] = (mem_m[idx] & ~wen) | (din & wen);
      end else begin
        q.push_back('{due: cyc + 1, d: mem_m[idx]});
        if (op == OP_RC) begin
          busy     = 1'b1;
          pend_idx = idx;
          pend_wen = wen;
        end
      end
    end
    #1;
    chk("req_rdy", DW'(rdy), DW'(!busy));
    chk("init_done", DW'(init_done), DW'(1'b1));
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rd_vld_pulse", DW'(rd_vld), DW'(1'b1));
      chk("rd_dout", rd_dout, q[0].d);
      last_d = q[0].d;
      void'(q.pop_front());
    end else begin
      chk("rd_vld_idle", DW'(rd_vld), DW'(1'b0));
      chk("rd_dout_hold", rd_dout, last_d);
    end
  endtask

  task automatic issue(input logic [1:0] o, input int i, input logic [DW-1:0] d, input logic [DW-1:0] w);
    vld = 1'b1;
    op  = o;
    idx = TIW'(i);
    din = d;
    wen = w;
    tick();
    vld = 1'b0;
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Count ready-low cycles from release; abort_at>0 stops after that many edges.
  task automatic release_and_init(input int abort_at);
    int  n;
    bit  done;
    rst_n = 1'b1;
`ifdef L2C_DIRTY_INIT_EN
    n    = (rdy === 1'b0) ? 1 : 0;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      if (abort_at > 0 && i == abort_at) return;
      @(posedge clk);
      #1;
      if (rdy === 1'b0) n++;
      else done = 1'b1;
    end
    chk("init_len", DW'(n), DW'(DEPTH));
    chk("init_done_end", DW'(init_done), DW'(1'b1));
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
`else
    n    = abort_at;
    done = 1'b1;
    chk("rdy_first_cycle", DW'(rdy), DW'(done));
    chk("init_done_noinit", DW'(init_done), DW'(1'b1));
`endif
  endtask

  task automatic apply_reset();
    vld   = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_rd_vld", DW'(rd_vld), DW'(1'b0));
    chk("rst_rd_dout", rd_dout, '0);
    chk("rst_init_done", DW'(init_done), DW'(RST_INIT_DONE));
    q.delete();
    busy   = 1'b0;
    last_d = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] ones;
    ones  = '1;
    rst_n = 1'b1;
    vld   = 1'b0;
    op    = OP_RD;
    idx   = '0;
    din   = '0;
    wen   = '0;
    busy  = 1'b0;
    last_d = '0;
    #2;
    apply_reset();
    release_and_init(0);

`ifdef L2C_DIRTY_INIT_EN
    for (int i = 0; i < DEPTH; i++) issue(OP_RD, i, '0, '0);
    idle(3);
    // Reset part-way through the sweep, then a full sweep must follow.
    apply_reset();
    release_and_init(100);
    rst_n = 1'b0;
    #1;
    chk("abort_init_done", DW'(init_done), DW'(1'b0));
    chk("abort_rd_vld", DW'(rd_vld), DW'(1'b0));
    @(posedge clk);
    #1;
    release_and_init(0);
    for (int i = 0; i < 8; i++) issue(OP_RD, i * 61, '0, '0);
    idle(3);
`else
    for (int i = 0; i < DEPTH; i++) issue(OP_WR, i, rnd_dw(), ones);
    idle(1);
`endif

    // Masked write then read: rd_vld exactly two edges after the read accept.
    issue(OP_WR, 5, '0, ones);
    issue(OP_WR, 5, ones, DW'(144'h1FF));
    issue(OP_RD, 5, '0, '0);
    idle(3);

    // Read-and-clear; a write offered during the clear cycle must be ignored.
    issue(OP_WR, 5, DW'(144'h1FF), ones);
    issue(OP_RC, 5, '0, DW'(144'h0FF));
    issue(OP_WR, 5, ones, ones);
    issue(OP_RD, 5, '0, '0);
    idle(3);

    // Back-to-back reads and program order around a same-index write.
    issue(OP_RD, 1, '0, '0);
    issue(OP_RD, 2, '0, '0);
    issue(OP_RD, 3, '0, '0);
    issue(OP_RD, 1, '0, '0);
    issue(OP_WR, 1, ones, ones);
    issue(OP_RD, 2, '0, '0);
    issue(OP_RD, 3, '0, '0);
    issue(OP_RD, 1, '0, '0);
    issue(2'b11, 1, '0, '0);
    idle(3);

    // Random traffic on a small index window to force collisions.
    for (int n = 0; n < 400; n++) begin
      vld = ($urandom_range(0, 3) != 0);
      op  = 2'($urandom_range(0, 3));
      idx = TIW'($urandom_range(0, 7));
      din = rnd_dw();
      wen = ($urandom_range(0, 3) == 0) ? ones : rnd_dw();
      tick();
    end
    idle(3);

    // Reset during the clear cycle drops the clear and its read pulse.
    issue(OP_WR, 2, ones, ones);
    issue(OP_RC, 2, '0, ones);
    apply_reset();
    release_and_init(0);
    issue(OP_RD, 2, '0, '0);
    idle(3);

    chk("queue_drained", DW'(q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
